mem_access_ctrl: RTL and testbench

- Sequences data-memory accesses issued by the memory pipeline stage onto a multi-cycle data-memory port using a req/ready handshake.
- Stalls the pipeline until each access completes.
- Generates byte enables and store-lane replication, sign/zero-extends load data, and times out hung accesses.
- Sits between the execute→memory pipeline register outputs and the data memory. The hazard logic consumes its stall output.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/load_extend.sv | 37 +++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/ready data-memory port between the access controller (master) and data memory (slave).
interface mem_access_ctrl_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a raw read word and sign/zero-extends it.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane[4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_i[8*gi +: 8];
    end
  endgenerate

  // Halfword selection uses addr[1] only, so an odd halfword address reads the aligned half.
  assign byte_sel = lane[addr_i];
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences memory-stage loads/stores onto a multi-cycle req/ready port, stalling the pipeline.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultsrcM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  bus_error,
  mem_access_ctrl_if.master     mem_bus
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_err
`endif
);

  state_t                   state_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     req_q;
  logic                     we_q;
  logic [31:0]              addr_q;
  logic [31:0]              wdata_q;
  logic [3:0]               be_q;
  logic [2:0]               funct3_q;
  logic [1:0]               addr_lo_q;
  logic                     is_load_q;
  logic [31:0]              read_data_q;
  logic                     bus_error_q;

  logic                     access_d;
  logic [3:0]               be_d;
  logic [31:0]              wdata_d;
  logic [31:0]              ext_data;
  logic                     timeout_hit;

  assign access_d    = MemWriteM | (ResultsrcM == RESULTSRC_LOAD);
  assign timeout_hit = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    case (funct3M)
      F3_B, F3_BU: begin
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      F3_H, F3_HU: begin
        be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_d;
  logic misalign_err_q;

  always_comb begin
    misaligned_d = 1'b0;
    if (is_half(funct3M))
      misaligned_d = ALUResultM[0];
    else if (!is_byte(funct3M))
      misaligned_d = |ALUResultM[1:0];
  end

  assign misalign_err = misalign_err_q;
`endif

  // Uses the captured low address bits and funct3, since the pipeline inputs may move on.
  load_extend u_load_extend (
    .rdata_i  (mem_bus.mem_rdata),
    .funct3_i (funct3_q),
    .addr_i   (addr_lo_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      is_load_q   <= 1'b0;
      read_data_q <= '0;
      bus_error_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          bus_error_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_err_q <= 1'b0;
          if (access_d && misaligned_d) begin
            misalign_err_q <= 1'b1;
            read_data_q    <= '0;
            state_q        <= DONE;
          end else
`endif
          if (access_d) begin
            addr_q    <= {ALUResultM[31:2], 2'b00};
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= MemWriteM;
            req_q     <= 1'b1;
            cnt_q     <= '0;
            funct3_q  <= funct3M;
            addr_lo_q <= ALUResultM[1:0];
            is_load_q <= ~MemWriteM;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          if (mem_bus.mem_ready) begin
            if (is_load_q)
              read_data_q <= ext_data;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (timeout_hit) begin
            req_q       <= 1'b0;
            bus_error_q <= 1'b1;
            read_data_q <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          bus_error_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_err_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The IDLE term is combinational so the access instruction is frozen in its first cycle.
  assign StallM = ((state_q == IDLE) && access_d) || (state_q == WAIT);

  assign ReadDataM         = read_data_q;
  assign bus_error         = bus_error_q;
  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign mem_bus.mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl plus hand sequences for back-to-back, reset and misalign cases.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM;
  logic [1:0]  ResultsrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if mem_bus ();

  mem_access_ctrl #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (64),
    .TIMEOUT_WIDTH  (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .ResultsrcM (ResultsrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .bus_error  (bus_error),
    .mem_bus    (mem_bus)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          k;        // WAIT cycle (1-based) in which mem_ready is raised; 0 = never
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    int          e_stall;
    logic        e_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    ResultsrcM = 2'b00;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    MemWriteM  = we;
    ResultsrcM = rs;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls = 0;
    int waits  = 0;
    int guard  = 0;
    bit seen   = 0;
    @(negedge clk);
    drive(v.we, v.rsrc, v.f3, v.addr, v.wd);
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    #1;
    while (StallM === 1'b1 && guard < 200) begin
      stalls++;
      guard++;
      if (mem_bus.mem_req === 1'b1) begin
        waits++;
        if (!seen) begin
          seen = 1;
          check($sformatf("v%0d mem_addr", idx), mem_bus.mem_addr, v.e_addr);
          check($sformatf("v%0d mem_we", idx), 32'(mem_bus.mem_we), 32'(v.we));
          if (v.we) begin
            check($sformatf("v%0d mem_be", idx), 32'(mem_bus.mem_be), 32'(v.e_be));
            check($sformatf("v%0d mem_wdata", idx), mem_bus.mem_wdata, v.e_wdata);
          end
        end
        if (waits == v.k) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = v.rd;
        end else begin
          mem_bus.mem_ready = 1'b0;
          mem_bus.mem_rdata = 32'hA5A5A5A5;
        end
      end
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d stall_bound: StallM still high after %0d cycles, required to fall", idx, guard);
    end
    check($sformatf("v%0d req_seen", idx), 32'(seen), 32'd1);
    check($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.e_stall));
    check($sformatf("v%0d ReadDataM", idx), ReadDataM, v.e_rdata);
    check($sformatf("v%0d bus_error_done", idx), 32'(bus_error), 32'(v.e_berr));
    check($sformatf("v%0d mem_req_done", idx), 32'(mem_bus.mem_req), 32'd0);
    idle_inputs();
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d bus_error_after", idx), 32'(bus_error), 32'd0);
    $display("vec %0d: we=%0b f3=%03b addr=0x%08h stalls=%0d ReadDataM=0x%08h bus_error=%0b",
             idx, v.we, v.f3, v.addr, stalls, ReadDataM, v.e_berr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // we rsrc f3 addr wd rd k | e_addr e_be e_wdata e_rdata e_stall e_berr
    vecs.push_back('{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 32'h100, 4'hF, 32'hDEADBEEF, 32'h00000000, 4, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b000, 32'h203, 32'h0, 32'h80112233, 1, 32'h200, 4'h8, 32'h0, 32'hFFFFFF80, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b100, 32'h203, 32'h0, 32'h80112233, 1, 32'h200, 4'h8, 32'h0, 32'h00000080, 2, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 3'b001, 32'h32, 32'h0000ABCD, 32'h0, 2, 32'h30, 4'hC, 32'hABCDABCD, 32'h00000080, 3, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b101, 32'h32, 32'h0, 32'hABCD1234, 1, 32'h30, 4'hC, 32'h0, 32'h0000ABCD, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b001, 32'h30, 32'h0, 32'h12348001, 1, 32'h30, 4'h3, 32'h0, 32'hFFFF8001, 2, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 3'b000, 32'h101, 32'h00000055, 32'h0, 1, 32'h100, 4'h2, 32'h55555555, 32'hFFFF8001, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 32'h100, 4'h2, 32'h0, 32'h0000007F, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b010, 32'h104, 32'h0, 32'h12345678, 4, 32'h104, 4'hF, 32'h0, 32'h12345678, 5, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b011, 32'h10, 32'h0, 32'hCAFEF00D, 1, 32'h10, 4'hF, 32'h0, 32'hCAFEF00D, 2, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 3'b010, 32'h20, 32'h01020304, 32'h99999999, 1, 32'h20, 4'hF, 32'h01020304, 32'hCAFEF00D, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b010, 32'h40, 32'h0, 32'h0, 0, 32'h40, 4'hF, 32'h0, 32'h00000000, 65, 1'b1});
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h89ABCDEF, 1, 32'h100, 4'hF, 32'h0, 32'h89ABCDEF, 2, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'b001, 32'h31, 32'h0, 32'h7777F00F, 1, 32'h30, 4'h3, 32'h0, 32'hFFFFF00F, 2, 1'b0});
`endif

    rst = 1'b1;
    idle_inputs();
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst StallM", 32'(StallM), 32'd0);
    check("rst ReadDataM", ReadDataM, 32'd0);
    check("rst mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst mem_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst mem_be", 32'(mem_bus.mem_be), 32'd0);
    check("rst mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst mem_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst bus_error", 32'(bus_error), 32'd0);
    rst = 1'b0;

    // mem_ready while idle must not capture data or stall
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("idle_ready ReadDataM", ReadDataM, 32'd0);
    check("idle_ready StallM", 32'(StallM), 32'd0);
    check("idle_ready mem_req", 32'(mem_bus.mem_req), 32'd0);
    $display("reset/idle checks done");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Back-to-back load then store, then reset in the middle of a third access
    @(negedge clk);
    drive(1'b0, 2'b01, 3'b010, 32'h8, 32'h0);
    #1;
    check("b2b ld idle StallM", 32'(StallM), 32'd1);
    check("b2b ld idle mem_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check("b2b ld wait mem_req", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("b2b ld done StallM", 32'(StallM), 32'd0);
    check("b2b ld ReadDataM", ReadDataM, 32'h0BADF00D);
    drive(1'b1, 2'b00, 3'b010, 32'hC, 32'h11223344);
    mem_bus.mem_ready = 1'b0;
    #1;
    check("b2b done no stall", 32'(StallM), 32'd0);
    @(negedge clk);
    check("b2b st idle StallM", 32'(StallM), 32'd1);
    check("b2b st idle mem_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check("b2b st mem_req", 32'(mem_bus.mem_req), 32'd1);
    check("b2b st mem_we", 32'(mem_bus.mem_we), 32'd1);
    check("b2b st mem_addr", mem_bus.mem_addr, 32'hC);
    check("b2b st mem_wdata", mem_bus.mem_wdata, 32'h11223344);
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    check("b2b st done StallM", 32'(StallM), 32'd0);
    check("b2b st done mem_req", 32'(mem_bus.mem_req), 32'd0);
    drive(1'b0, 2'b01, 3'b000, 32'h5, 32'h0);
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rstw idle StallM", 32'(StallM), 32'd1);
    @(negedge clk);
    check("rstw wait mem_req", 32'(mem_bus.mem_req), 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rstw mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rstw StallM", 32'(StallM), 32'd0);
    check("rstw ReadDataM", ReadDataM, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstw idle mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rstw idle StallM", 32'(StallM), 32'd0);
    $display("back-to-back and reset-in-wait sequence done");

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    drive(1'b0, 2'b01, 3'b010, 32'h102, 32'h0);
    #1;
    check("mis StallM", 32'(StallM), 32'd1);
    @(negedge clk);
    check("mis done StallM", 32'(StallM), 32'd0);
    check("mis misalign_err", 32'(misalign_err), 32'd1);
    check("mis mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("mis ReadDataM", ReadDataM, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("mis err cleared", 32'(misalign_err), 32'd0);
    check("mis no req", 32'(mem_bus.mem_req), 32'd0);
    $display("misalign trap sequence done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
